// File: rtl/rect_paint_engine.sv
// Rectangle fill engine: walks a latched rectangle in raster order, one pixel per clock,
// presenting x/y/colour with a plot strobe, then pulses done for one cycle.
module rect_paint_engine #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                clear,
    input  logic [X_W-1:0]      x_init,
    input  logic [Y_W-1:0]      y_init,
    input  logic [X_W-1:0]      w,
    input  logic [Y_W-1:0]      h,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic                hold,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, PAINT, DONE} state_t;

    localparam logic [X_W:0] SW     = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SH     = (Y_W+1)'(SCREEN_H);
    localparam logic [X_W:0] CLR_XL = (X_W+1)'(SCREEN_W - 1);
    localparam logic [Y_W:0] CLR_YL = (Y_W+1)'(SCREEN_H - 1);
    localparam logic [X_W:0] X_ONE  = (X_W+1)'(1);
    localparam logic [Y_W:0] Y_ONE  = (Y_W+1)'(1);

    state_t              state_q, state_d;
    logic [X_W:0]        x_q, x_d, x0_q, x0_d, xl_q, xl_d;
    logic [Y_W:0]        y_q, y_d, yl_q, yl_d;
    logic [COLOUR_W-1:0] col_q, col_d;
    logic                zero_q, zero_d;
    logic                plot_q, plot_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [X_W:0] x_ext, w_ext;
    logic [Y_W:0] y_ext, h_ext;

    assign x_ext = {1'b0, x_init};
    assign w_ext = {1'b0, w};
    assign y_ext = {1'b0, y_init};
    assign h_ext = {1'b0, h};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        x0_d    = x0_q;
        xl_d    = xl_q;
        yl_d    = yl_q;
        col_d   = col_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (clear) begin
                    x0_d    = '0;
                    xl_d    = CLR_XL;
                    yl_d    = CLR_YL;
                    col_d   = '0;
                    zero_d  = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = PAINT;
                end else if (start) begin
                    // Last column/row held one bit wider so x0+W-1 never wraps.
                    x0_d    = x_ext;
                    xl_d    = x_ext + w_ext - X_ONE;
                    yl_d    = y_ext + h_ext - Y_ONE;
                    col_d   = colour_in;
                    zero_d  = (w == '0) || (h == '0);
                    x_d     = x_ext;
                    y_d     = y_ext;
                    state_d = PAINT;
                end
            end
            PAINT: begin
                if (!hold) begin
                    if (zero_q) begin
                        state_d = DONE;
                    end else if (x_q == xl_q) begin
                        if (y_q == yl_q) begin
                            state_d = DONE;
                        end else begin
                            x_d = x0_q;
                            y_d = y_q + Y_ONE;
                        end
                    end else begin
                        x_d = x_q + X_ONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        plot_d = (state_d == PAINT) && !zero_d && (x_d < SW) && (y_d < SH);
        busy_d = (state_d == PAINT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            xl_q    <= '0;
            yl_q    <= '0;
            col_q   <= '0;
            zero_q  <= 1'b0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            xl_q    <= xl_d;
            yl_q    <= yl_d;
            col_q   <= col_d;
            zero_q  <= zero_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // A stalled pixel is presented but not written.
    assign plot   = plot_q & ~hold;
    assign busy   = busy_q;
    assign done   = done_q;
    assign x      = x_q[X_W-1:0];
    assign y      = y_q[Y_W-1:0];
    assign colour = col_q;

endmodule

// File: tb/tb_rect_paint_engine.sv
// Bench for rect_paint_engine: pixel-index model checked every cycle, plus directed
// fills with hand-computed pixel counts and done latencies.
module tb_rect_paint_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, clear, hold;
    logic [7:0] x_init, w;
    logic [6:0] y_init, h;
    logic [2:0] colour_in;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int n_total = 0;
    int n_pass  = 0;

    rect_paint_engine dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .x_init(x_init), .y_init(y_init), .w(w), .h(h), .colour_in(colour_in),
        .hold(hold), .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a fill is a list of W*H raster pixels indexed by m_idx.
    logic m_act, m_dn;
    int   m_x0, m_y0, m_w, m_h, m_col, m_idx, m_xo, m_yo;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act <= 0; m_dn <= 0; m_x0 <= 0; m_y0 <= 0; m_w <= 0; m_h <= 0;
            m_col <= 0; m_idx <= 0; m_xo <= 0; m_yo <= 0;
        end else if (m_dn) begin
            m_dn <= 0;
        end else if (m_act) begin
            if (!hold) begin
                if (m_idx + 1 >= m_w * m_h) begin
                    m_act <= 0;
                    m_dn  <= 1;
                end else begin
                    m_idx <= m_idx + 1;
                    m_xo  <= m_x0 + (m_idx + 1) % m_w;
                    m_yo  <= m_y0 + (m_idx + 1) / m_w;
                end
            end
        end else if (clear) begin
            m_act <= 1; m_idx <= 0; m_x0 <= 0; m_y0 <= 0; m_w <= 160; m_h <= 120;
            m_col <= 0; m_xo <= 0; m_yo <= 0;
        end else if (start) begin
            m_act <= 1; m_idx <= 0; m_x0 <= int'(x_init); m_y0 <= int'(y_init);
            m_w <= int'(w); m_h <= int'(h); m_col <= int'(colour_in);
            m_xo <= int'(x_init); m_yo <= int'(y_init);
        end
    end

    always @(negedge clk) begin
        int exp_plot;
        exp_plot = (m_act && !hold && m_w * m_h > 0 && m_xo < 160 && m_yo < 120) ? 1 : 0;
        chk("model_plot", int'(plot), exp_plot);
        chk("model_busy", int'(busy), int'(m_act));
        chk("model_done", int'(done), int'(m_dn));
        chk("model_x", int'(x), m_xo % 256);
        chk("model_y", int'(y), m_yo % 128);
        chk("model_colour", int'(colour), m_col);
    end

    task automatic op(input string name, input bit do_clear, input int sx, input int sy,
                      input int sw, input int sh, input int sc, input int hold_after,
                      input int hold_len, input bit stray, input int exp_plots,
                      input int exp_busy, input int exp_done);
        int plots = 0, busys = 0, dcyc = -1;
        x_init = sx[7:0]; y_init = sy[6:0]; w = sw[7:0]; h = sh[6:0]; colour_in = sc[2:0];
        start = 1; clear = do_clear;
        @(posedge clk); #1;
        start = 0; clear = 0;
        for (int n = 1; n <= 20000; n++) begin
            hold = (n > hold_after) && (n <= hold_after + hold_len);
            if (stray) begin
                start = (n == 3);
                if (n == 3) begin x_init = 8'd90; y_init = 7'd90; w = 8'd9; h = 7'd9; colour_in = 3'd7; end
            end
            #1;
            if (plot) plots++;
            if (busy) busys++;
            if (done) begin dcyc = n; break; end
            @(posedge clk); #1;
        end
        hold = 0; start = 0;
        chk({name, "_plots"}, plots, exp_plots);
        chk({name, "_busy_cycles"}, busys, exp_busy);
        chk({name, "_done_cycle"}, dcyc, exp_done);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_idle_done"}, int'(done), 0);
    endtask

    initial begin
        int dones;
        reset = 1; start = 0; clear = 0; hold = 0;
        x_init = 0; y_init = 0; w = 0; h = 0; colour_in = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        reset = 0;
        @(posedge clk); #1;

        op("basic", 0, 10, 20, 3, 2, 5, 1000, 0, 0, 6, 6, 7);
        chk("basic_last_x", int'(x), 12);
        chk("basic_last_y", int'(y), 21);
        chk("basic_colour", int'(colour), 5);

        op("clear", 1, 33, 44, 5, 5, 6, 100000, 0, 0, 19200, 19200, 19201);
        chk("clear_last_x", int'(x), 159);
        chk("clear_last_y", int'(y), 119);
        chk("clear_colour", int'(colour), 0);

        op("clip", 0, 158, 119, 4, 2, 3, 1000, 0, 0, 2, 8, 9);

        op("hold", 0, 5, 6, 2, 2, 3, 1, 3, 1, 4, 7, 8);
        chk("hold_colour", int'(colour), 3);

        op("zero", 0, 7, 8, 0, 5, 2, 1000, 0, 0, 0, 1, 2);

        x_init = 8'd1; y_init = 7'd1; w = 8'd3; h = 7'd3; colour_in = 3'd2; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1;
        #1;
        chk("rstmid_plot", int'(plot), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_x", int'(x), 0);
        chk("rstmid_y", int'(y), 0);
        @(posedge clk); #3;
        reset = 0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("rstmid_no_done", dones, 0);

        op("after_rst", 0, 10, 20, 3, 2, 5, 1000, 0, 0, 6, 6, 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
